// File: rtl/kp_emu_pkg.sv
// Shared definitions for the keypad matrix emulator: state encoding, key fields,
// LFSR taps and the idle row value.
package kp_emu_pkg;

    typedef enum logic [2:0] {
        StIdle        = 3'd0,
        StPressBounce = 3'd1,
        StHold        = 3'd2,
        StRelBounce   = 3'd3,
        StGap         = 3'd4
    } state_e;

    localparam int unsigned KEY_ROW_MSB = 3;
    localparam int unsigned KEY_ROW_LSB = 2;
    localparam int unsigned KEY_COL_MSB = 1;
    localparam int unsigned KEY_COL_LSB = 0;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  ROW_IDLE  = 4'b1111;

    // Galois LFSR, shift right; never reaches zero from a non-zero state.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/kp_bounce_timer.sv
// Pseudo-random bounce interval timer: each load takes the next interval from the
// LFSR and advances it; expire marks the last cycle of the interval.
module kp_bounce_timer
    import kp_emu_pkg::*;
#(
    parameter int unsigned BOUNCE_MAX_LOG2 = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam logic [BOUNCE_MAX_LOG2-1:0] CNT_ONE = 1;

    logic [15:0]                lfsr_q;
    logic [BOUNCE_MAX_LOG2-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= '0;
        end else if (load) begin
            cnt_q  <= lfsr_q[BOUNCE_MAX_LOG2-1:0];
            lfsr_q <= lfsr_step(lfsr_q);
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // A loaded value v gives an interval of v+1 cycles.
    assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Emulates one 4x4 keypad key with programmable hold time and LFSR-driven contact
// bounce, answering the scanner's active-low column drive on the row lines.
module keypad_matrix_emulator
    import kp_emu_pkg::*;
#(
    parameter int unsigned BOUNCE_EDGES    = 4,
    parameter int unsigned BOUNCE_MAX_LOG2 = 4,
    parameter int unsigned GAP_CYCLES      = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic        cmd_bounce,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        contact
);

    localparam bit          HAS_BOUNCE = (BOUNCE_EDGES != 0);
    localparam logic [7:0]  EDGES_INIT = 8'(BOUNCE_EDGES);
    localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic        contact_q, contact_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  edges_q, edges_d;
    logic [3:0]  key_q;
    logic [15:0] hold_q;
    logic        bounce_q;
    logic        accept;
    logic        tmr_load, tmr_enable, tmr_expire;

    // Hold of 0 behaves as 1; the counter counts down to zero inclusive.
    function automatic logic [15:0] hold_load(input logic [15:0] h);
        return (h == 16'd0) ? 16'd0 : h - 16'd1;
    endfunction

    assign accept     = cmd_valid && (state_q == StIdle);
    assign tmr_enable = (state_q == StPressBounce) || (state_q == StRelBounce);

    kp_bounce_timer #(
        .BOUNCE_MAX_LOG2 (BOUNCE_MAX_LOG2),
        .LFSR_SEED       (LFSR_SEED)
    ) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (tmr_load),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            contact_q <= 1'b0;
            cnt_q     <= '0;
            edges_q   <= '0;
            key_q     <= '0;
            hold_q    <= '0;
            bounce_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            contact_q <= contact_d;
            cnt_q     <= cnt_d;
            edges_q   <= edges_d;
            if (accept) begin
                key_q    <= cmd_key;
                hold_q   <= cmd_hold;
                bounce_q <= cmd_bounce;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        contact_d = contact_q;
        cnt_d     = cnt_q;
        edges_d   = edges_q;
        tmr_load  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    contact_d = 1'b1;
                    if (cmd_bounce && HAS_BOUNCE) begin
                        state_d  = StPressBounce;
                        edges_d  = EDGES_INIT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StHold;
                        cnt_d   = hold_load(cmd_hold);
                    end
                end
            end
            StPressBounce, StRelBounce: begin
                if (tmr_expire) begin
                    contact_d = ~contact_q;
                    edges_d   = edges_q - 8'd1;
                    if (edges_q == 8'd1) begin
                        if (state_q == StPressBounce) begin
                            state_d = StHold;
                            cnt_d   = hold_load(hold_q);
                        end else begin
                            state_d = StGap;
                            cnt_d   = GAP_LOAD;
                        end
                    end else begin
                        tmr_load = 1'b1;
                    end
                end
            end
            StHold: begin
                if (cnt_q == 16'd0) begin
                    contact_d = 1'b0;
                    if (bounce_q && HAS_BOUNCE) begin
                        state_d  = StRelBounce;
                        edges_d  = EDGES_INIT;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StGap;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any interval expiry; GAP and IDLE ignore it.
        if (abort && (state_q inside {StPressBounce, StHold, StRelBounce})) begin
            state_d   = StGap;
            contact_d = 1'b0;
            edges_d   = '0;
            cnt_d     = GAP_LOAD;
            tmr_load  = 1'b0;
        end
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StGap) && (cnt_q == 16'd0);
        contact   = contact_q;
        row_out   = ROW_IDLE;
        if (contact_q && !col_in[key_q[KEY_COL_MSB:KEY_COL_LSB]]) begin
            row_out[key_q[KEY_ROW_MSB:KEY_ROW_LSB]] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Self-checking bench for keypad_matrix_emulator against a per-cycle contact model.
module tb_keypad_matrix_emulator;

    localparam int unsigned BE   = 4;
    localparam int unsigned GAP  = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  col_in = 4'hF;
    logic [3:0]  row_out;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_key = 4'h0;
    logic [15:0] cmd_hold = 16'h0;
    logic        cmd_bounce = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, contact;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_lfsr = SEED;

    keypad_matrix_emulator #(
        .BOUNCE_EDGES    (BE),
        .BOUNCE_MAX_LOG2 (4),
        .GAP_CYCLES      (GAP),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .col_in     (col_in),
        .row_out    (row_out),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_key    (cmd_key),
        .cmd_hold   (cmd_hold),
        .cmd_bounce (cmd_bounce),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .contact    (contact)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Keypad seen by the scanner: closed key pulls its row low when its column is driven.
    function automatic logic [3:0] ref_row(input bit c, input logic [3:0] key,
                                           input logic [3:0] cols);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = !(c && (i == int'(key[3:2])) && (cols[key[1:0]] == 1'b0));
        end
        return r;
    endfunction

    // Issue one press at the current negedge and check every cycle until idle again.
    task automatic run_press(input logic [3:0] key, input logic [15:0] hold, input logic bnc,
                             input bit rand_col, input logic [3:0] col0, input string name,
                             output int trans);
        bit q[$];
        int iv, h;
        bit prev;
        logic [3:0] er;
        if (bnc && BE > 0) begin
            for (int e = 0; e < int'(BE); e++) begin
                iv = int'(m_lfsr[3:0]) + 1;
                m_lfsr = ref_lfsr(m_lfsr);
                repeat (iv) q.push_back((e % 2) == 0);
            end
        end
        h = (hold == 0) ? 1 : int'(hold);
        repeat (h) q.push_back(1'b1);
        if (bnc && BE > 0) begin
            for (int e = 0; e < int'(BE); e++) begin
                iv = int'(m_lfsr[3:0]) + 1;
                m_lfsr = ref_lfsr(m_lfsr);
                repeat (iv) q.push_back((e % 2) == 1);
            end
        end
        repeat (GAP) q.push_back(1'b0);

        cmd_valid = 1'b1; cmd_key = key; cmd_hold = hold; cmd_bounce = bnc; col_in = col0;
        @(posedge clk);
        prev = 1'b0;
        trans = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (rand_col) col_in = 4'($urandom);
            #1;
            er = ref_row(q[i], key, col_in);
            if (contact !== prev) trans++;
            prev = contact;
            checks += 4;
            if (contact !== q[i]) begin
                errors++;
                $display("FAIL %s contact cyc %0d: got %b want %b", name, i + 1, contact, q[i]);
            end
            if (row_out !== er) begin
                errors++;
                $display("FAIL %s row_out cyc %0d: got %b want %b", name, i + 1, row_out, er);
            end
            if (done !== (i == q.size() - 1)) begin
                errors++;
                $display("FAIL %s done cyc %0d: got %b want %b", name, i + 1, done,
                         (i == q.size() - 1));
            end
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cyc %0d: got %b want 1", name, i + 1, busy);
            end
        end
        @(negedge clk);
        checks += 2;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready after done: got %b want 1", name, cmd_ready);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after done: got %b want 0", name, busy);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout waiting idle: busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks += 5;
        if (row_out !== 4'b1111) begin errors++; $display("FAIL reset row_out: got %b want 1111", row_out); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        if (contact !== 1'b0) begin errors++; $display("FAIL reset contact: got %b want 0", contact); end
        @(negedge clk);
        resetn = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
    endtask

    task automatic test_clean_press();
        int t;
        run_press(4'h6, 16'd10, 1'b0, 1'b0, 4'b1011, "clean", t);
        checks++;
        if (t !== 2) begin errors++; $display("FAIL clean transitions: got %0d want 2", t); end
    endtask

    task automatic test_col_sweep();
        logic [3:0] cols [4];
        logic [3:0] want [4];
        cols[0] = 4'b1110; cols[1] = 4'b1101; cols[2] = 4'b0111; cols[3] = 4'b1011;
        want[0] = 4'b1111; want[1] = 4'b1111; want[2] = 4'b1111; want[3] = 4'b1101;
        cmd_valid = 1'b1; cmd_key = 4'h6; cmd_hold = 16'd20; cmd_bounce = 1'b0; col_in = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            col_in = cols[i];
            #1;
            checks++;
            if (row_out !== want[i]) begin
                errors++;
                $display("FAIL colsweep col=%b: got %b want %b", cols[i], row_out, want[i]);
            end
        end
        col_in = 4'b0000;
        #1;
        checks++;
        if (row_out !== 4'b1101) begin
            errors++; $display("FAIL colsweep all-low: got %b want 1101", row_out);
        end
        wait_idle("colsweep");
    endtask

    task automatic test_bounce();
        int t;
        run_press(4'hF, 16'd20, 1'b1, 1'b0, 4'b0111, "bounce", t);
        checks++;
        if (t !== 10) begin errors++; $display("FAIL bounce transitions: got %0d want 10", t); end
    endtask

    task automatic test_abort();
        cmd_valid = 1'b1; cmd_key = 4'h3; cmd_hold = 16'd50; cmd_bounce = 1'b0; col_in = 4'b0111;
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin cmd_key = 4'h9; cmd_hold = 16'd3; end
            #1;
            checks += 2;
            if (contact !== 1'b1) begin errors++; $display("FAIL abort hold%0d contact: got %b want 1", i, contact); end
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort hold%0d ready: got %b want 0", i, cmd_ready); end
        end
        abort = 1'b1;
        for (int i = 6; i <= 13; i++) begin
            @(negedge clk);
            abort = 1'b0;
            #1;
            checks += 3;
            if (contact !== 1'b0 || row_out !== 4'b1111) begin
                errors++; $display("FAIL abort gap%0d contact/row: got %b/%b want 0/1111", i, contact, row_out);
            end
            if (done !== (i == 13)) begin errors++; $display("FAIL abort done cyc %0d: got %b want %b", i, done, (i == 13)); end
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort ready cyc %0d: got %b want 0", i, cmd_ready); end
        end
        @(negedge clk);
        checks += 2;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort idle ready: got %b want 1", cmd_ready); end
        if (contact !== 1'b0) begin errors++; $display("FAIL abort idle contact: got %b want 0", contact); end
        @(negedge clk);
        cmd_valid = 1'b0;
        col_in = 4'b1101;
        #1;
        checks += 2;
        if (contact !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL held cmd accept: contact=%b busy=%b want 1 1", contact, busy);
        end
        if (row_out !== 4'b1011) begin errors++; $display("FAIL held cmd row_out: got %b want 1011", row_out); end
        wait_idle("abort");
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort in idle: ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_hold_zero();
        int t;
        run_press(4'hC, 16'd0, 1'b0, 1'b0, 4'b1110, "hold0", t);
        checks++;
        if (t !== 2) begin errors++; $display("FAIL hold0 transitions: got %0d want 2", t); end
    endtask

    task automatic test_back_to_back();
        int t;
        for (int n = 0; n < 5; n++) begin
            run_press(4'($urandom), 16'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1'b1,
                      4'($urandom), "random", t);
        end
    endtask

    task automatic test_async_reset();
        int t;
        cmd_valid = 1'b1; cmd_key = 4'hA; cmd_hold = 16'd5; cmd_bounce = 1'b1; col_in = 4'b1011;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (row_out !== 4'b1011) begin errors++; $display("FAIL areset pre row_out: got %b want 1011", row_out); end
        #2;
        resetn = 1'b0;
        #1;
        checks += 4;
        if (row_out !== 4'b1111) begin errors++; $display("FAIL areset row_out: got %b want 1111", row_out); end
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL areset ready: got %b want 1", cmd_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL areset busy: got %b want 0", busy); end
        if (contact !== 1'b0) begin errors++; $display("FAIL areset contact: got %b want 0", contact); end
        @(negedge clk);
        resetn = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
        run_press(4'h5, 16'd4, 1'b1, 1'b1, 4'b1101, "replay", t);
        checks++;
        if (t !== 10) begin errors++; $display("FAIL replay transitions: got %0d want 10", t); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_col_sweep();
        test_bounce();
        test_abort();
        test_hold_zero();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
